gray_to_color: RTL and testbench
================================

# gray_to_color

Pixel-stream false-colour mapper. Converts one 8-bit grey value per valid cycle into an 8-bit RGB triple using one of eight fixed colormaps selected at run time. Sits in the video/image pipeline after grey-level generation and before RGB sinks such as display or file writers. Single-stage registered pipeline, no back-pressure.

## Interface
Parameters: none.
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- gray_in  input  8  grey level 0..255
- data_valid  input  1  gray_in/colormap_sel valid this cycle
- colormap_sel  input  3  000 JET, 001 HSV, 010 RAINBOW, 011 OCEAN, 100 SUMMER, 101 WINTER, 110 AUTUMN, 111 BONE
- r_out, g_out, b_out  output  8 each  mapped colour
- data_out_valid  output  1  r/g/b_out updated this cycle

## Operation
All arithmetic is unsigned and evaluated at ≥10 bits; results are never allowed to wrap. Unless a map states otherwise, each channel is 8-bit exact. g denotes gray_in.
- JET: g<64 → (0,0,4g); g<128 → (0,4(g−64),255); g<192 → (4(g−128),255,255−4(g−128)); else (255,255−4(g−192),0).
- HSV: g<43 → (255,6g,0); g<85 → (255−6(g−43),255,0); g<128 → (0,255,6(g−85)); g<170 → (0,255−6(g−128),255); g<213 → (6(g−170),0,255); else (255,0,255−6(g−213)).
- RAINBOW: g<37 → (255,0,0); g<74 → (255,7(g−37),0); g<111 → (255,255,0); g<148 → (255−7(g−111),255,0); g<185 → (0,255,7(g−148)); g<222 → (0,255−7(g−185),255); else (min(8(g−222),255),0,255). This final segment saturates, so g=254 gives r=255 and g=255 gives r=255.
- OCEAN: r = g<192 ? 0 : 4(g−192); gch = g<128 ? 0 : 2(g−128); b = g.
- SUMMER: (g, 128+(g>>1), 102).
- WINTER: (0, g, 255−(g>>1)).
- AUTUMN: (255, g, 0).
- BONE: base = (7g)>>3; r = base + (g≥192 ? (g−192)>>1 : 0); gch = base + (g≥96 ? (g−96)>>3 : 0); b = base + (g>>3).
- Multiplies by 4, 6, 7 and 8 are implemented with shifts and adds. No hardware multipliers.

## Timing
- Reset: r_out, g_out, b_out and data_out_valid are all 0, asynchronously.
- Latency is 1 cycle. If data_valid=1 at edge N, then after edge N the outputs hold map(colormap_sel, gray_in) as sampled at edge N, and data_out_valid=1.
- data_out_valid is a registered copy of data_valid. It is high for exactly one cycle per accepted input.
- When data_valid=0, r/g/b_out hold their last value indefinitely.
- colormap_sel is sampled only together with data_valid. It may change every cycle, and back-to-back valid pixels may use different maps.
- Full throughput: one pixel per cycle is accepted continuously.
- If rst_n is asserted mid-stream, any in-flight pixel is discarded and outputs clear to 0.

## Structure
- Shared package gray_to_color_pkg holds the 3-bit colormap codes (CMAP_JET … CMAP_BONE) and the segment boundary constants (64/128/192, 43/85/128/170/213, 37/74/111/148/185/222).
- One natural sub-module is gray_to_color_lut: purely combinational, taking (sel, gray) and producing rgb, with a case per map.
- The top level holds the output registers and the valid flop.

## Test plan
- Reset: hold rst_n=0, then release → all outputs are 0. After one pulse with g=0 on JET → (0,0,0) with data_out_valid high for 1 cycle.
- JET directed points: g=0 → (0,0,0); g=128 → (0,255,255); g=255 → (255,3,0). Each result appears one cycle after the valid pulse and is still held the following cycle.
- HSV: g=64 → (129,255,0); g=192 → (132,0,255). RAINBOW: g=37 → (255,0,0); g=111 → (255,255,0); g=185 → (0,255,255); g=255 → (255,0,255) (saturation).
- Other maps at g=200: OCEAN (32,144,200), SUMMER (200,228,102), WINTER (0,200,155), AUTUMN (255,200,0), BONE (179,188,200).
- Streaming: 256 consecutive valid cycles with g=0..255 while colormap_sel cycles 0..7 → data_out_valid stays high for 256 cycles, and every output matches the golden model one cycle later.
- Reset mid-stream: assert rst_n during a valid burst → outputs are 0 immediately, and the first post-reset pixel maps correctly.

Source files
------------

// File: rtl/gray_to_color_pkg.sv
// gray_to_color shared definitions: colormap codes, segment
// boundaries and shift-add arithmetic helpers.
package gray_to_color_pkg;

  typedef enum logic [2:0] {
    CMAP_JET     = 3'd0,
    CMAP_HSV     = 3'd1,
    CMAP_RAINBOW = 3'd2,
    CMAP_OCEAN   = 3'd3,
    CMAP_SUMMER  = 3'd4,
    CMAP_WINTER  = 3'd5,
    CMAP_AUTUMN  = 3'd6,
    CMAP_BONE    = 3'd7
  } cmap_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [7:0] JET_B0 = 8'd64;
  localparam logic [7:0] JET_B1 = 8'd128;
  localparam logic [7:0] JET_B2 = 8'd192;

  localparam logic [7:0] HSV_B0 = 8'd43;
  localparam logic [7:0] HSV_B1 = 8'd85;
  localparam logic [7:0] HSV_B2 = 8'd128;
  localparam logic [7:0] HSV_B3 = 8'd170;
  localparam logic [7:0] HSV_B4 = 8'd213;

  localparam logic [7:0] RBW_B0 = 8'd37;
  localparam logic [7:0] RBW_B1 = 8'd74;
  localparam logic [7:0] RBW_B2 = 8'd111;
  localparam logic [7:0] RBW_B3 = 8'd148;
  localparam logic [7:0] RBW_B4 = 8'd185;
  localparam logic [7:0] RBW_B5 = 8'd222;

  localparam logic [7:0] OCN_R0 = 8'd192;
  localparam logic [7:0] OCN_G0 = 8'd128;

  localparam logic [7:0] BONE_R0 = 8'd192;
  localparam logic [7:0] BONE_G0 = 8'd96;

  localparam logic [7:0] SUM_B  = 8'd102;
  localparam logic [7:0] SUM_G0 = 8'd128;
  localparam logic [7:0] FULL   = 8'd255;

  function automatic logic [10:0] mul4(input logic [7:0] x);
    return {1'b0, x, 2'b00};
  endfunction

  function automatic logic [10:0] mul6(input logic [7:0] x);
    return {1'b0, x, 2'b00} + {2'b00, x, 1'b0};
  endfunction

  function automatic logic [10:0] mul7(input logic [7:0] x);
    return {x, 3'b000} - {3'b000, x};
  endfunction

  function automatic logic [10:0] mul8(input logic [7:0] x);
    return {x, 3'b000};
  endfunction

  // Clamp a wide intermediate into one colour channel.
  function automatic logic [7:0] sat8(input logic [10:0] v);
    return (v > 11'd255) ? 8'd255 : v[7:0];
  endfunction

  function automatic logic [7:0] inv8(input logic [10:0] v);
    return FULL - sat8(v);
  endfunction

endpackage

// File: rtl/gray_to_color_lut.sv
// gray_to_color_lut: combinational grey-to-RGB mapping,
// one branch per colormap, shift-add arithmetic only.
module gray_to_color_lut
  import gray_to_color_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [7:0] gray,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  logic [7:0]  d;
  logic [10:0] t;
  logic [7:0]  base;

  always_comb begin
    r    = '0;
    g    = '0;
    b    = '0;
    d    = '0;
    t    = mul7(gray);
    base = t[10:3];
    unique case (sel)
      CMAP_JET: begin
        if (gray < JET_B0) begin
          b = sat8(mul4(gray));
        end else if (gray < JET_B1) begin
          d = gray - JET_B0;
          g = sat8(mul4(d));
          b = FULL;
        end else if (gray < JET_B2) begin
          d = gray - JET_B1;
          r = sat8(mul4(d));
          g = FULL;
          b = inv8(mul4(d));
        end else begin
          d = gray - JET_B2;
          r = FULL;
          g = inv8(mul4(d));
        end
      end
      CMAP_HSV: begin
        if (gray < HSV_B0) begin
          r = FULL;
          g = sat8(mul6(gray));
        end else if (gray < HSV_B1) begin
          d = gray - HSV_B0;
          r = inv8(mul6(d));
          g = FULL;
        end else if (gray < HSV_B2) begin
          d = gray - HSV_B1;
          g = FULL;
          b = sat8(mul6(d));
        end else if (gray < HSV_B3) begin
          d = gray - HSV_B2;
          g = inv8(mul6(d));
          b = FULL;
        end else if (gray < HSV_B4) begin
          d = gray - HSV_B3;
          r = sat8(mul6(d));
          b = FULL;
        end else begin
          d = gray - HSV_B4;
          r = FULL;
          b = inv8(mul6(d));
        end
      end
      CMAP_RAINBOW: begin
        if (gray < RBW_B0) begin
          r = FULL;
        end else if (gray < RBW_B1) begin
          d = gray - RBW_B0;
          r = FULL;
          g = sat8(mul7(d));
        end else if (gray < RBW_B2) begin
          r = FULL;
          g = FULL;
        end else if (gray < RBW_B3) begin
          d = gray - RBW_B2;
          r = inv8(mul7(d));
          g = FULL;
        end else if (gray < RBW_B4) begin
          d = gray - RBW_B3;
          g = FULL;
          b = sat8(mul7(d));
        end else if (gray < RBW_B5) begin
          d = gray - RBW_B4;
          g = inv8(mul7(d));
          b = FULL;
        end else begin
          // Last segment overshoots 255 by g=254 and must clamp.
          d = gray - RBW_B5;
          r = sat8(mul8(d));
          b = FULL;
        end
      end
      CMAP_OCEAN: begin
        if (gray >= OCN_R0) begin
          d = gray - OCN_R0;
          r = sat8(mul4(d));
        end
        if (gray >= OCN_G0) begin
          g = {gray[6:0], 1'b0};
        end
        b = gray;
      end
      CMAP_SUMMER: begin
        r = gray;
        g = SUM_G0 + {1'b0, gray[7:1]};
        b = SUM_B;
      end
      CMAP_WINTER: begin
        g = gray;
        b = FULL - {1'b0, gray[7:1]};
      end
      CMAP_AUTUMN: begin
        r = FULL;
        g = gray;
      end
      CMAP_BONE: begin
        r = base;
        g = base;
        b = base + {3'b000, gray[7:3]};
        if (gray >= BONE_R0) begin
          d = gray - BONE_R0;
          r = base + {1'b0, d[7:1]};
        end
        if (gray >= BONE_G0) begin
          g = base + {3'b000, gray[7:3] - 5'd12};
        end
      end
      default: begin
        r = '0;
        g = '0;
        b = '0;
      end
    endcase
  end

endmodule

// File: rtl/gray_to_color.sv
// gray_to_color: single-stage registered false-colour mapper,
// one pixel per cycle, outputs hold while idle.
module gray_to_color
  import gray_to_color_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] gray_in,
  input  logic       data_valid,
  input  logic [2:0] colormap_sel,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       data_out_valid
);

  rgb_t lut_rgb;
  rgb_t rgb_q;
  logic valid_q;

  gray_to_color_lut u_lut (
    .sel  (colormap_sel),
    .gray (gray_in),
    .r    (lut_rgb.r),
    .g    (lut_rgb.g),
    .b    (lut_rgb.b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= data_valid;
      if (data_valid) begin
        rgb_q <= lut_rgb;
      end
    end
  end

  assign r_out          = rgb_q.r;
  assign g_out          = rgb_q.g;
  assign b_out          = rgb_q.b;
  assign data_out_valid = valid_q;

endmodule

// File: tb/tb_gray_to_color.sv
// tb_gray_to_color: directed points, streaming sweep, random
// pixels and mid-stream reset against an arithmetic model.
module tb_gray_to_color;

  logic       clk;
  logic       rst_n;
  logic [7:0] gray_in;
  logic       data_valid;
  logic [2:0] colormap_sel;
  logic [7:0] r_out;
  logic [7:0] g_out;
  logic [7:0] b_out;
  logic       data_out_valid;

  int checks;
  int failures;

  gray_to_color dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .gray_in        (gray_in),
    .data_valid     (data_valid),
    .colormap_sel   (colormap_sel),
    .r_out          (r_out),
    .g_out          (g_out),
    .b_out          (b_out),
    .data_out_valid (data_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clip(int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [23:0] ref_map(int sel, int g);
    int r, gc, b;
    r = 0; gc = 0; b = 0;
    case (sel)
      0: if (g < 64) b = 4*g;
         else if (g < 128) begin gc = 4*(g-64); b = 255; end
         else if (g < 192) begin
           r = 4*(g-128); gc = 255; b = 255-4*(g-128);
         end else begin r = 255; gc = 255-4*(g-192); end
      1: if (g < 43) begin r = 255; gc = 6*g; end
         else if (g < 85) begin r = 255-6*(g-43); gc = 255; end
         else if (g < 128) begin gc = 255; b = 6*(g-85); end
         else if (g < 170) begin gc = 255-6*(g-128); b = 255; end
         else if (g < 213) begin r = 6*(g-170); b = 255; end
         else begin r = 255; b = 255-6*(g-213); end
      2: if (g < 37) r = 255;
         else if (g < 74) begin r = 255; gc = 7*(g-37); end
         else if (g < 111) begin r = 255; gc = 255; end
         else if (g < 148) begin r = 255-7*(g-111); gc = 255; end
         else if (g < 185) begin gc = 255; b = 7*(g-148); end
         else if (g < 222) begin gc = 255-7*(g-185); b = 255; end
         else begin r = clip(8*(g-222)); b = 255; end
      3: begin
           r = (g < 192) ? 0 : 4*(g-192);
           gc = (g < 128) ? 0 : 2*(g-128);
           b = g;
         end
      4: begin r = g; gc = 128 + g/2; b = 102; end
      5: begin gc = g; b = 255 - g/2; end
      6: begin r = 255; gc = g; end
      default: begin
        r = (7*g)/8 + ((g >= 192) ? (g-192)/2 : 0);
        gc = (7*g)/8 + ((g >= 96) ? (g-96)/8 : 0);
        b = (7*g)/8 + g/8;
      end
    endcase
    return {8'(r), 8'(gc), 8'(b)};
  endfunction

  task automatic check(input string tag, input logic [24:0] obs,
                       input logic [24:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] outs();
    return {data_out_valid, r_out, g_out, b_out};
  endfunction

  // One isolated pixel: result one cycle later, then held.
  task automatic pixel(input string tag, input int sel, input int g,
                       input logic [23:0] want);
    @(negedge clk);
    colormap_sel = 3'(sel);
    gray_in      = 8'(g);
    data_valid   = 1'b1;
    @(negedge clk);
    data_valid   = 1'b0;
    gray_in      = 8'($urandom);
    colormap_sel = 3'($urandom);
    check({tag, "_out"}, outs(), {1'b1, want});
    check({tag, "_ref"}, {1'b1, want}, {1'b1, ref_map(sel, g)});
    @(negedge clk);
    check({tag, "_hold"}, outs(), {1'b0, want});
  endtask

  initial begin
    logic [23:0] prev;
    int sel_q[$];
    int g_q[$];
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    data_valid   = 1'b0;
    gray_in      = 8'd77;
    colormap_sel = 3'd0;
    repeat (3) @(negedge clk);
    check("reset", outs(), 25'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", outs(), 25'd0);

    pixel("jet0", 0, 0, 24'h000000);
    pixel("jet128", 0, 128, 24'h00ffff);
    pixel("jet255", 0, 255, {8'd255, 8'd3, 8'd0});
    pixel("hsv64", 1, 64, {8'd129, 8'd255, 8'd0});
    pixel("hsv192", 1, 192, {8'd132, 8'd0, 8'd255});
    pixel("rbw37", 2, 37, {8'd255, 8'd0, 8'd0});
    pixel("rbw111", 2, 111, {8'd255, 8'd255, 8'd0});
    pixel("rbw185", 2, 185, {8'd0, 8'd255, 8'd255});
    pixel("rbw254", 2, 254, {8'd255, 8'd0, 8'd255});
    pixel("rbw255", 2, 255, {8'd255, 8'd0, 8'd255});
    pixel("ocean200", 3, 200, {8'd32, 8'd144, 8'd200});
    pixel("summer200", 4, 200, {8'd200, 8'd228, 8'd102});
    pixel("winter200", 5, 200, {8'd0, 8'd200, 8'd155});
    pixel("autumn200", 6, 200, {8'd255, 8'd200, 8'd0});
    pixel("bone200", 7, 200, {8'd179, 8'd188, 8'd200});
    pixel("bone255", 7, 255, {8'd254, 8'd242, 8'd254});

    // Streaming sweep: output of pixel i checked at the next negedge.
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      if (i > 0)
        check("stream", outs(), {1'b1, ref_map((i-1) % 8, i-1)});
      if (i < 256) begin
        data_valid   = 1'b1;
        gray_in      = 8'(i);
        colormap_sel = 3'(i % 8);
      end else begin
        data_valid = 1'b0;
      end
    end
    prev = ref_map(255 % 8, 255);
    @(negedge clk);
    check("stream_hold", outs(), {1'b0, prev});

    // Random traffic with gaps, scoreboard queue of accepted pixels.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (g_q.size() > 0) begin
        prev = ref_map(sel_q.pop_front(), g_q.pop_front());
        check("rand", outs(), {1'b1, prev});
      end else if (i > 0) begin
        check("rand_idle", outs(), {1'b0, prev});
      end
      data_valid   = ($urandom_range(0, 3) != 0);
      gray_in      = 8'($urandom);
      colormap_sel = 3'($urandom);
      if (data_valid) begin
        sel_q.push_back(int'(colormap_sel));
        g_q.push_back(int'(gray_in));
      end
    end

    // Mid-stream reset while a pixel is in flight.
    @(negedge clk);
    data_valid   = 1'b1;
    gray_in      = 8'd200;
    colormap_sel = 3'd6;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_clear", outs(), 25'd0);
    @(negedge clk);
    check("midreset_held", outs(), 25'd0);
    rst_n = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    check("midreset_drop", outs(), 25'd0);
    pixel("after_reset", 1, 100, ref_map(1, 100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
